// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART byte stream to command frame sequencer with inter-byte timeout
// Optional build macro: UART_FRAME_CHECKSUM_EN adds a third (checksum) byte and the checksum_err output.
module uart_rx_frame_ctrl #(
    parameter int unsigned clock_bit     = 5208,
    parameter int unsigned timeout_bytes = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic       timeout_err,
    output logic       overrun_err,
    input  logic       err_clear,
`ifdef UART_FRAME_CHECKSUM_EN
    output logic       checksum_err,
`endif
    output logic       busy
);

    // Silence of one full timeout window, in clock cycles (10 bit times per byte).
    localparam logic [31:0] LIMIT    = 32'(timeout_bytes * 10 * clock_bit);
    localparam logic [31:0] LIMIT_M1 = LIMIT - 32'd1;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_HOLD      = 2'd2,
        ST_WAIT_SUM  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  frame_cmd_q, frame_cmd_d;
    logic [7:0]  frame_data_q, frame_data_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_err_q, overrun_err_d;
    logic        overrun_set;
    logic        in_wait;
    logic        tmo_hit;
    logic        byte_accepted;
`ifdef UART_FRAME_CHECKSUM_EN
    logic        checksum_err_q, checksum_err_d;
    logic        sum_ok;
`endif

    // Decode of timing conditions shared by the next-state and output logic.
    always_comb begin
`ifdef UART_FRAME_CHECKSUM_EN
        in_wait = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_SUM);
        sum_ok  = (rx_data == (frame_cmd_q ^ frame_data_q));
`else
        in_wait = (state_q == ST_WAIT_DATA);
`endif
        // A byte arriving in the deadline cycle beats the timeout.
        tmo_hit       = in_wait && !rx_done && (cnt_q == LIMIT_M1);
        // In HOLD a byte is only taken when the pending frame is acked alongside it.
        byte_accepted = rx_done && ((state_q != ST_HOLD) || frame_ack);
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for frame assembly and handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_done) begin
`ifdef UART_FRAME_CHECKSUM_EN
                    state_d = ST_WAIT_SUM;
`else
                    state_d = ST_HOLD;
`endif
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    state_d = rx_done ? ST_WAIT_DATA : ST_IDLE;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_WAIT_SUM: begin
                if (rx_done) begin
                    state_d = sum_ok ? ST_HOLD : ST_IDLE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: byte latching, error pulses and the silence counter.
    always_comb begin
        frame_cmd_d   = frame_cmd_q;
        frame_data_d  = frame_data_q;
        timeout_err_d = 1'b0;
        overrun_set   = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        checksum_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    frame_cmd_d = rx_data;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_done) begin
                    frame_data_d = rx_data;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (rx_done) begin
                    if (frame_ack) begin
                        frame_cmd_d = rx_data;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_WAIT_SUM: begin
                if (rx_done) begin
                    checksum_err_d = !sum_ok;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase

        // A new drop outranks a clear request in the same cycle.
        overrun_err_d = overrun_set || (overrun_err_q && !err_clear);

        // Counter restarts on each accepted byte and saturates while waiting.
        if (byte_accepted) begin
            cnt_d = 32'd0;
        end else if (in_wait && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; a reset drops any partial or pending frame silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= 32'd0;
            frame_cmd_q   <= 8'd0;
            frame_data_q  <= 8'd0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            checksum_err_q <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_data_q  <= frame_data_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_FRAME_CHECKSUM_EN
            checksum_err_q <= checksum_err_d;
`endif
        end
    end

    assign frame_cmd   = frame_cmd_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = (state_q == ST_HOLD);
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_FRAME_CHECKSUM_EN
    assign checksum_err = checksum_err_q;
`endif

endmodule
